cache: RTL and testbench
========================

// Module: cache
// PURPOSE
//  Generic set-associative, write-back, write-allocate cache storage engine with
//  valid/ready ports on both sides. Upper (hc_*) port faces the requesting cache
//  controller (e.g. L1I/L1D wrapper); lower (lc_*) port faces the next level (LLC).
//  It never answers the hc side on a fill: after a miss the controller must re-issue
//  the request once the fill is installed.
// PARAMETERS
//  A          4     associativity (ways per set)
//  B          64    line size in bytes (power of 2)
//  C          1536  capacity in bytes; NUM_SETS = C/(A*B) (6 by default, need not be 2^n)
//  W          512   hc data word width in bits; W divides 8*B
//  ADDR_BITS  64    physical address width
// PORTS
//  clk_in         in   1        clock
//  rst_N_in       in   1        async active-low reset
//  cs_in          in   1        chip select; 0 = freeze (no state/output change)
//  flush_in       in   1        write back dirty lines, then invalidate all
//  hc_valid_in    in   1        upper request valid
//  hc_ready_in    in   1        upper accepts hc response
//  hc_addr_in     in   ADDR_BITS  request byte address
//  hc_value_in    in   W        write word
//  hc_we_in       in   1        1 = write, 0 = read
//  cache_line_in  in   8*B      full line for line write
//  cl_in          in   1        with hc_we_in: write full line (no fetch)
//  lc_valid_out   out  1        lower request valid
//  lc_ready_out   out  1        ready to accept a fill
//  lc_addr_out    out  ADDR_BITS  line-aligned request/writeback address
//  lc_value_out   out  8*B      writeback line data
//  we_out         out  1        1 = writeback, 0 = line fetch
//  lc_valid_in    in   1        fill valid
//  lc_ready_in    in   1        lower accepted lc request
//  lc_addr_in     in   ADDR_BITS  fill address
//  lc_value_in    in   8*B      fill line
//  hc_valid_out   out  1        hit response valid
//  hc_ready_out   out  1        ready for new hc request
//  hc_we_out      out  1        response is a write ack
//  hc_addr_out    out  ADDR_BITS  address of responded request
//  hc_value_out   out  W        read word (write: word written)
// BEHAVIOUR
//  - Reset (async, rst_N_in=0): all outputs 0, all lines invalid/clean, victim ptrs 0, state IDLE.
//  - Address: off = addr[log2B-1:0]; blk = addr>>log2B; set = blk % NUM_SETS; tag = full blk.
//    Word select = off/(W/8); hc_addr_out/lc_addr_out are line-aligned (offset bits 0).
//  - All outputs registered. cs_in=0 holds everything. hc_ready_out=1 only in IDLE;
//    lc_ready_out=1 in IDLE and WAIT_FILL.
//  - States: IDLE, LOOKUP, HC_RESP, WRITEBACK, LC_REQ, WAIT_FILL, FLUSH.
//  - IDLE priority: flush_in > lc_valid_in (fill) > hc_valid_in.
//  - IDLE + hc_valid_in: latch addr/value/we/cl -> LOOKUP (1 cycle).
//    Read hit: HC_RESP, hc_valid_out=1, hc_we_out=0, hc_value_out=word. Write hit: update
//    word (or whole line if cl_in), set dirty, HC_RESP with hc_we_out=1. Hold until
//    hc_ready_in, then IDLE next cycle. Hit latency: hc_valid_out high 2 edges after accept.
//    Line write (cl_in) miss: allocate victim (writeback first if dirty), install, ack.
//  - Miss: victim = first invalid way else per-set round-robin ptr (ptr++ on replacement).
//    Dirty victim -> WRITEBACK: lc_valid_out=1, we_out=1, victim addr/line until lc_ready_in.
//    Then LC_REQ: lc_valid_out=1, we_out=0, lc_addr_out=line addr until lc_ready_in
//    -> WAIT_FILL. Victim is invalidated when the fetch is issued.
//  - Fill (lc_valid_in & lc_ready_out, IDLE or WAIT_FILL): install lc_value_in at lc_addr_in's
//    set; hit way if present else victim; valid, clean; -> IDLE. No hc response is produced.
//  - FLUSH: walk all sets/ways, each dirty line written back via lc port (we_out=1);
//    then invalidate all; IDLE. hc/lc ready low throughout.
//  - hc_valid_in while not ready is ignored (requester holds it). Reset mid-operation aborts.
// TESTING
//  1 Reset, read 0x1000 -> lc_valid_out=1, we_out=0, lc_addr_out=0x1000; no hc_valid_out.
//  2 Fill 0x1000 with 512'hA5..; re-read 0x1000 -> hc_valid_out=1, value=512'hA5.., 2-edge latency.
//  3 Write 0x1000 hit (W=512 value 0x55..), then 5 fills mapping to same set (stride 0x180)
//    -> one writeback we_out=1, lc_addr_out=0x1000, lc_value_out=0x55...
//  4 hc_ready_in held low 3 cycles -> hc_valid_out/value stable; IDLE one cycle after ready.
//  5 Fill and hc_valid_in same cycle in IDLE -> fill taken first, hc_ready_out=0 that cycle.
//  6 Dirty line then flush_in=1 -> single writeback; subsequent read misses; cs_in=0 freezes outputs.

Source files
------------

// File: rtl/cache.sv
// Set-associative write-back / write-allocate cache storage engine.
// The hc side gets responses only on hits; after a fill the requester re-issues its request.
module cache #(
  parameter int unsigned A         = 4,
  parameter int unsigned B         = 64,
  parameter int unsigned C         = 1536,
  parameter int unsigned W         = 512,
  parameter int unsigned ADDR_BITS = 64
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  input  logic                 cs_in,
  input  logic                 flush_in,
  input  logic                 hc_valid_in,
  input  logic                 hc_ready_in,
  input  logic [ADDR_BITS-1:0] hc_addr_in,
  input  logic [W-1:0]         hc_value_in,
  input  logic                 hc_we_in,
  input  logic [8*B-1:0]       cache_line_in,
  input  logic                 cl_in,
  output logic                 lc_valid_out,
  output logic                 lc_ready_out,
  output logic [ADDR_BITS-1:0] lc_addr_out,
  output logic [8*B-1:0]       lc_value_out,
  output logic                 we_out,
  input  logic                 lc_valid_in,
  input  logic                 lc_ready_in,
  input  logic [ADDR_BITS-1:0] lc_addr_in,
  input  logic [8*B-1:0]       lc_value_in,
  output logic                 hc_valid_out,
  output logic                 hc_ready_out,
  output logic                 hc_we_out,
  output logic [ADDR_BITS-1:0] hc_addr_out,
  output logic [W-1:0]         hc_value_out
);

  localparam int unsigned LB       = $clog2(B);
  localparam int unsigned NUM_SETS = C / (A * B);
  localparam int unsigned WORDS    = (8 * B) / W;
  localparam int unsigned WSEL_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int unsigned WAY_W    = (A > 1) ? $clog2(A) : 1;
  localparam int unsigned TAG_W    = ADDR_BITS - LB;
  localparam int unsigned LINE_W   = 8 * B;

  typedef enum logic [2:0] {IDLE, LOOKUP, HC_RESP, WRITEBACK, LC_REQ, WAIT_FILL, FLUSH} state_t;
  typedef enum logic [1:0] {OP_FETCH, OP_CL, OP_FILL} op_t;

  state_t state, state_next;
  op_t    op;

  logic [LINE_W-1:0] data_q  [NUM_SETS][A];
  logic [TAG_W-1:0]  tag_q   [NUM_SETS][A];
  logic [A-1:0]      valid_q [NUM_SETS];
  logic [A-1:0]      dirty_q [NUM_SETS];
  logic [WAY_W-1:0]  ptr_q   [NUM_SETS];

  logic [ADDR_BITS-1:0] req_addr;
  logic [W-1:0]         req_value;
  logic                 req_we, req_cl;
  logic [LINE_W-1:0]    line_buf;
  logic [WAY_W-1:0]     vict_way;
  logic [SET_W-1:0]     fset;
  logic [WAY_W-1:0]     fway;
  logic                 fl_busy;

  logic [TAG_W-1:0]     look_tag;
  logic [SET_W-1:0]     look_set;
  logic                 look_hit, look_repl, vict_dirty;
  logic [WAY_W-1:0]     look_hway, look_vict;
  logic [LINE_W-1:0]    vict_line, hit_line, merged;
  logic [ADDR_BITS-1:0] vict_addr;
  logic [WSEL_W-1:0]    widx;
  logic [W-1:0]         hit_word, buf_word;

  logic take_flush, take_fill, take_hc, fill_wb, bump_ptr;
  logic fl_dirty, flush_adv, flush_last;
  logic wr_en, wr_dirty;
  logic [WAY_W-1:0]  wr_way;
  logic [LINE_W-1:0] wr_line;

  function automatic logic [ADDR_BITS-1:0] align(input logic [ADDR_BITS-1:0] a);
    return {a[ADDR_BITS-1:LB], {LB{1'b0}}};
  endfunction

  // One lookup path: fill address while waiting for fills, latched request otherwise.
  always_comb begin
    look_tag  = (state == IDLE || state == WAIT_FILL) ? lc_addr_in[ADDR_BITS-1:LB]
                                                     : req_addr[ADDR_BITS-1:LB];
    look_set  = SET_W'(look_tag % TAG_W'(NUM_SETS));
    look_hit  = 1'b0;
    look_hway = '0;
    look_vict = ptr_q[look_set];
    look_repl = 1'b1;
    for (int unsigned i = 0; i < A; i++) begin
      if (valid_q[look_set][i] && tag_q[look_set][i] == look_tag) begin
        look_hit  = 1'b1;
        look_hway = WAY_W'(i);
      end
      if (!valid_q[look_set][A-1-i]) begin
        look_vict = WAY_W'(A - 1 - i);
        look_repl = 1'b0;
      end
    end
    vict_dirty = valid_q[look_set][look_vict] && dirty_q[look_set][look_vict];
    vict_line  = data_q[look_set][look_vict];
    vict_addr  = {tag_q[look_set][look_vict], {LB{1'b0}}};
    hit_line   = data_q[look_set][look_hway];
    widx       = WSEL_W'(req_addr[LB-1:0] / (W / 8));
    hit_word   = hit_line[widx*W +: W];
    buf_word   = line_buf[widx*W +: W];
    merged     = hit_line;
    merged[widx*W +: W] = req_value;
  end

  always_comb begin
    state_next = state;
    take_flush = 1'b0;
    take_fill  = 1'b0;
    take_hc    = 1'b0;
    fill_wb    = !look_hit && vict_dirty;
    fl_dirty   = valid_q[fset][fway] && dirty_q[fset][fway];
    flush_adv  = fl_busy ? lc_ready_in : !fl_dirty;
    flush_last = (fset == SET_W'(NUM_SETS - 1)) && (fway == WAY_W'(A - 1));
    wr_en      = 1'b0;
    wr_dirty   = 1'b0;
    wr_way     = vict_way;
    wr_line    = line_buf;
    case (state)
      IDLE, WAIT_FILL: begin
        if (state == IDLE && flush_in) begin
          take_flush = 1'b1;
          state_next = FLUSH;
        end else if (lc_valid_in && lc_ready_out) begin
          take_fill  = 1'b1;
          state_next = fill_wb ? WRITEBACK : IDLE;
          if (!fill_wb) begin
            wr_en   = 1'b1;
            wr_way  = look_hit ? look_hway : look_vict;
            wr_line = lc_value_in;
          end
        end else if (state == IDLE && hc_valid_in && hc_ready_out) begin
          take_hc    = 1'b1;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (look_hit) begin
          state_next = HC_RESP;
          if (req_we) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            wr_way   = look_hway;
            wr_line  = req_cl ? line_buf : merged;
          end
        end else if (vict_dirty) begin
          state_next = WRITEBACK;
        end else if (req_we && req_cl) begin
          state_next = HC_RESP;
          wr_en      = 1'b1;
          wr_dirty   = 1'b1;
          wr_way     = look_vict;
        end else begin
          state_next = LC_REQ;
        end
      end
      HC_RESP:   if (hc_ready_in) state_next = IDLE;
      WRITEBACK: begin
        if (lc_ready_in) begin
          case (op)
            OP_FETCH: state_next = LC_REQ;
            OP_CL:    state_next = HC_RESP;
            default:  state_next = IDLE;
          endcase
          if (op != OP_FETCH) begin
            wr_en    = 1'b1;
            wr_dirty = (op == OP_CL);
          end
        end
      end
      LC_REQ:    if (lc_ready_in) state_next = WAIT_FILL;
      FLUSH:     if (flush_adv && flush_last) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    wr_en    = wr_en && cs_in;
    bump_ptr = !look_hit && look_repl && (take_fill || state == LOOKUP);
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) state <= IDLE;
    else if (cs_in) state <= state_next;
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      data_q[look_set][wr_way] <= wr_line;
      tag_q[look_set][wr_way]  <= look_tag;
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      lc_valid_out <= 1'b0;
      lc_ready_out <= 1'b0;
      lc_addr_out  <= '0;
      lc_value_out <= '0;
      we_out       <= 1'b0;
      hc_valid_out <= 1'b0;
      hc_ready_out <= 1'b0;
      hc_we_out    <= 1'b0;
      hc_addr_out  <= '0;
      hc_value_out <= '0;
      req_addr     <= '0;
      req_value    <= '0;
      req_we       <= 1'b0;
      req_cl       <= 1'b0;
      line_buf     <= '0;
      vict_way     <= '0;
      op           <= OP_FETCH;
      fset         <= '0;
      fway         <= '0;
      fl_busy      <= 1'b0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (cs_in) begin
      // A taken fill costs one ready-low cycle so a same-cycle hc request waits.
      hc_ready_out <= (state_next == IDLE) && !take_fill;
      lc_ready_out <= ((state_next == IDLE) && !take_fill) || (state_next == WAIT_FILL);
      if (wr_en) begin
        valid_q[look_set][wr_way] <= 1'b1;
        dirty_q[look_set][wr_way] <= wr_dirty;
      end
      if (bump_ptr)
        ptr_q[look_set] <= (ptr_q[look_set] == WAY_W'(A - 1)) ? '0 : ptr_q[look_set] + 1'b1;
      case (state)
        IDLE, WAIT_FILL: begin
          if (take_flush) begin
            fset    <= '0;
            fway    <= '0;
            fl_busy <= 1'b0;
          end else if (take_fill) begin
            req_addr <= lc_addr_in;
            line_buf <= lc_value_in;
            vict_way <= look_vict;
            op       <= OP_FILL;
            if (fill_wb) begin
              lc_valid_out <= 1'b1;
              we_out       <= 1'b1;
              lc_addr_out  <= vict_addr;
              lc_value_out <= vict_line;
            end
          end else if (take_hc) begin
            req_addr  <= hc_addr_in;
            req_value <= hc_value_in;
            req_we    <= hc_we_in;
            req_cl    <= cl_in;
            line_buf  <= cache_line_in;
          end
        end
        LOOKUP: begin
          vict_way <= look_vict;
          op       <= (req_we && req_cl) ? OP_CL : OP_FETCH;
          if (look_hit) begin
            hc_valid_out <= 1'b1;
            hc_we_out    <= req_we;
            hc_addr_out  <= align(req_addr);
            hc_value_out <= !req_we ? hit_word : (req_cl ? buf_word : req_value);
          end else if (vict_dirty) begin
            lc_valid_out <= 1'b1;
            we_out       <= 1'b1;
            lc_addr_out  <= vict_addr;
            lc_value_out <= vict_line;
          end else if (req_we && req_cl) begin
            hc_valid_out <= 1'b1;
            hc_we_out    <= 1'b1;
            hc_addr_out  <= align(req_addr);
            hc_value_out <= buf_word;
          end else begin
            lc_valid_out <= 1'b1;
            we_out       <= 1'b0;
            lc_addr_out  <= align(req_addr);
            valid_q[look_set][look_vict] <= 1'b0;
            dirty_q[look_set][look_vict] <= 1'b0;
          end
        end
        HC_RESP: begin
          if (hc_ready_in) begin
            hc_valid_out <= 1'b0;
            hc_we_out    <= 1'b0;
          end
        end
        WRITEBACK: begin
          if (lc_ready_in) begin
            we_out <= 1'b0;
            if (op == OP_FETCH) begin
              lc_addr_out <= align(req_addr);
              valid_q[look_set][vict_way] <= 1'b0;
              dirty_q[look_set][vict_way] <= 1'b0;
            end else begin
              lc_valid_out <= 1'b0;
              if (op == OP_CL) begin
                hc_valid_out <= 1'b1;
                hc_we_out    <= 1'b1;
                hc_addr_out  <= align(req_addr);
                hc_value_out <= buf_word;
              end
            end
          end
        end
        LC_REQ: if (lc_ready_in) lc_valid_out <= 1'b0;
        FLUSH: begin
          if (fl_busy) begin
            if (lc_ready_in) begin
              lc_valid_out        <= 1'b0;
              we_out              <= 1'b0;
              fl_busy             <= 1'b0;
              dirty_q[fset][fway] <= 1'b0;
            end
          end else if (fl_dirty) begin
            lc_valid_out <= 1'b1;
            we_out       <= 1'b1;
            lc_addr_out  <= {tag_q[fset][fway], {LB{1'b0}}};
            lc_value_out <= data_q[fset][fway];
            fl_busy      <= 1'b1;
          end
          if (flush_adv) begin
            if (fway == WAY_W'(A - 1)) begin
              fway <= '0;
              fset <= fset + 1'b1;
            end else begin
              fway <= fway + 1'b1;
            end
            if (flush_last) begin
              for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache.sv
// Directed bench for cache: miss/fetch, fill, hits, eviction writeback, backpressure,
// fill-vs-request priority, flush and chip-select freeze.
module tb_cache;
  logic         clk_in = 1'b0;
  logic         rst_N_in, cs_in, flush_in;
  logic         hc_valid_in, hc_ready_in, hc_we_in, cl_in;
  logic [63:0]  hc_addr_in;
  logic [511:0] hc_value_in, cache_line_in;
  logic         lc_valid_out, lc_ready_out, we_out;
  logic [63:0]  lc_addr_out;
  logic [511:0] lc_value_out;
  logic         lc_valid_in, lc_ready_in;
  logic [63:0]  lc_addr_in;
  logic [511:0] lc_value_in;
  logic         hc_valid_out, hc_ready_out, hc_we_out;
  logic [63:0]  hc_addr_out;
  logic [511:0] hc_value_out;

  int ntests = 0;
  int nfail  = 0;
  int n, extra;
  logic [7:0] b;

  cache #(.A(4), .B(64), .C(1536), .W(512), .ADDR_BITS(64)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in), .cs_in(cs_in), .flush_in(flush_in),
    .hc_valid_in(hc_valid_in), .hc_ready_in(hc_ready_in), .hc_addr_in(hc_addr_in),
    .hc_value_in(hc_value_in), .hc_we_in(hc_we_in), .cache_line_in(cache_line_in),
    .cl_in(cl_in), .lc_valid_out(lc_valid_out), .lc_ready_out(lc_ready_out),
    .lc_addr_out(lc_addr_out), .lc_value_out(lc_value_out), .we_out(we_out),
    .lc_valid_in(lc_valid_in), .lc_ready_in(lc_ready_in), .lc_addr_in(lc_addr_in),
    .lc_value_in(lc_value_in), .hc_valid_out(hc_valid_out), .hc_ready_out(hc_ready_out),
    .hc_we_out(hc_we_out), .hc_addr_out(hc_addr_out), .hc_value_out(hc_value_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_N_in = 1'b0; cs_in = 1'b1; flush_in = 1'b0;
    hc_valid_in = 1'b0; hc_ready_in = 1'b0; hc_we_in = 1'b0; cl_in = 1'b0;
    hc_addr_in = '0; hc_value_in = '0; cache_line_in = '0;
    lc_valid_in = 1'b0; lc_ready_in = 1'b0; lc_addr_in = '0; lc_value_in = '0;
    tick(); tick();
    check("rst_hc_ready", hc_ready_out, 0);
    check("rst_lc_ready", lc_ready_out, 0);
    check("rst_lc_valid", lc_valid_out, 0);
    check("rst_hc_valid", hc_valid_out, 0);
    rst_N_in = 1'b1;
    tick();
    check("idle_hc_ready", hc_ready_out, 1);
    check("idle_lc_ready", lc_ready_out, 1);

    // 1: read miss -> line fetch
    hc_valid_in = 1'b1; hc_addr_in = 64'h1000;
    tick();
    hc_valid_in = 1'b0;
    check("t1_busy", hc_ready_out, 0);
    tick();
    check("t1_lc_valid", lc_valid_out, 1);
    check("t1_we", we_out, 0);
    check("t1_lc_addr", lc_addr_out, 64'h1000);
    check("t1_no_hc_valid", hc_valid_out, 0);
    lc_ready_in = 1'b1;
    tick();
    lc_ready_in = 1'b0;
    check("t1_req_done", lc_valid_out, 0);
    check("t1_fill_ready", lc_ready_out, 1);

    // 2: fill then hit with 2-edge latency
    lc_valid_in = 1'b1; lc_addr_in = 64'h1000; lc_value_in = {64{8'hA5}};
    tick();
    lc_valid_in = 1'b0;
    check("t2_fill_bubble", hc_ready_out, 0);
    check("t2_no_resp", hc_valid_out, 0);
    tick();
    check("t2_ready", hc_ready_out, 1);
    hc_valid_in = 1'b1; hc_addr_in = 64'h1000;
    tick();
    hc_valid_in = 1'b0;
    check("t2_lat1", hc_valid_out, 0);
    tick();
    check("t2_hit_valid", hc_valid_out, 1);
    check("t2_hit_we", hc_we_out, 0);
    check("t2_hit_value", hc_value_out, {64{8'hA5}});
    check("t2_hit_addr", hc_addr_out, 64'h1000);
    hc_ready_in = 1'b1;
    tick();
    hc_ready_in = 1'b0;
    check("t2_resp_done", hc_valid_out, 0);

    // 3: write hit, then five same-set fills force one dirty eviction
    hc_valid_in = 1'b1; hc_addr_in = 64'h1000; hc_we_in = 1'b1; hc_value_in = {64{8'h55}};
    tick();
    hc_valid_in = 1'b0; hc_we_in = 1'b0;
    tick();
    check("t3_wr_ack", hc_we_out, 1);
    check("t3_wr_value", hc_value_out, {64{8'h55}});
    hc_ready_in = 1'b1;
    tick();
    hc_ready_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      lc_valid_in = 1'b1; lc_addr_in = 64'h1000 + 64'(i) * 64'h180; lc_value_in = {64{b}};
      tick();
      lc_valid_in = 1'b0;
      if (i == 4) begin
        check("t3_wb_valid", lc_valid_out, 1);
        check("t3_wb_we", we_out, 1);
        check("t3_wb_addr", lc_addr_out, 64'h1000);
        check("t3_wb_value", lc_value_out, {64{8'h55}});
        lc_ready_in = 1'b1;
        tick();
        lc_ready_in = 1'b0;
        check("t3_wb_done", lc_valid_out, 0);
        check("t3_wb_ready", lc_ready_out, 1);
      end else begin
        check("t3_no_wb", lc_valid_out, 0);
        tick();
      end
    end

    // 4: response held under hc_ready_in backpressure
    hc_valid_in = 1'b1; hc_addr_in = 64'h1780;
    tick();
    hc_valid_in = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t4_hold_valid", hc_valid_out, 1);
      check("t4_hold_value", hc_value_out, {64{8'h05}});
      tick();
    end
    hc_ready_in = 1'b1;
    tick();
    hc_ready_in = 1'b0;
    check("t4_released", hc_valid_out, 0);
    check("t4_idle_ready", hc_ready_out, 1);

    // 5: fill wins over a same-cycle request
    lc_valid_in = 1'b1; lc_addr_in = 64'h2000; lc_value_in = {64{8'h3C}};
    hc_valid_in = 1'b1; hc_addr_in = 64'h2000;
    tick();
    lc_valid_in = 1'b0;
    check("t5_fill_first", hc_ready_out, 0);
    check("t5_no_fetch", lc_valid_out, 0);
    tick();
    check("t5_ready_back", hc_ready_out, 1);
    tick();
    hc_valid_in = 1'b0;
    check("t5_accepted", hc_ready_out, 0);
    tick();
    check("t5_hit_valid", hc_valid_out, 1);
    check("t5_hit_value", hc_value_out, {64{8'h3C}});
    hc_ready_in = 1'b1;
    tick();
    hc_ready_in = 1'b0;

    // 6: dirty line, flush, re-read misses, cs_in freeze
    hc_valid_in = 1'b1; hc_addr_in = 64'h2000; hc_we_in = 1'b1; hc_value_in = {64{8'hC3}};
    tick();
    hc_valid_in = 1'b0; hc_we_in = 1'b0;
    tick();
    check("t6_wr_ack", hc_we_out, 1);
    hc_ready_in = 1'b1;
    tick();
    hc_ready_in = 1'b0;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    check("t6_flush_hc_ready", hc_ready_out, 0);
    check("t6_flush_lc_ready", lc_ready_out, 0);
    n = 0;
    while (lc_valid_out !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("t6_flush_wb_seen", lc_valid_out, 1);
    check("t6_flush_we", we_out, 1);
    check("t6_flush_addr", lc_addr_out, 64'h2000);
    check("t6_flush_value", lc_value_out, {64{8'hC3}});
    lc_ready_in = 1'b1;
    tick();
    lc_ready_in = 1'b0;
    n = 0; extra = 0;
    while (hc_ready_out !== 1'b1 && n < 60) begin
      if (lc_valid_out === 1'b1) extra++;
      tick();
      n++;
    end
    check("t6_flush_done", hc_ready_out, 1);
    check("t6_single_wb", 512'(extra), 0);
    hc_valid_in = 1'b1; hc_addr_in = 64'h2000;
    tick();
    hc_valid_in = 1'b0;
    tick();
    check("t6_miss_fetch", lc_valid_out, 1);
    check("t6_miss_we", we_out, 0);
    check("t6_miss_addr", lc_addr_out, 64'h2000);
    check("t6_miss_no_hit", hc_valid_out, 0);
    cs_in = 1'b0; lc_ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_frozen_valid", lc_valid_out, 1);
      check("t6_frozen_addr", lc_addr_out, 64'h2000);
      check("t6_frozen_lc_ready", lc_ready_out, 0);
    end
    cs_in = 1'b1;
    tick();
    lc_ready_in = 1'b0;
    check("t6_unfrozen", lc_valid_out, 0);
    check("t6_wait_fill", lc_ready_out, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
